hero_level_sequencer: RTL

Game-flow controller for the H.E.R.O. design. It sequences the per-screen level-part renderers by driving a one-hot `level_enable` vector: only the active part is enabled, and all others hold their sprite tables and clear their outputs. It consumes each part's miner-rescue and death flags, tracks lives, and owns the bomb lifecycle (`bomb_pos_x/y`, `b_cnt`) shared by every level part. It sits between the input/character-motion logic and the level-part renderers; the VGA colour OR-tree is outside this block.

---
 rtl/hero_level_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/hero_level_sequencer.sv
// rtl/hero_level_sequencer.sv - H.E.R.O. game-flow sequencer: level parts, lives and bomb lifecycle
module hero_level_sequencer #(
    parameter int NUM_LEVELS   = 6,
    parameter int LIVES        = 3,
    parameter int PAUSE_FRAMES = 120,
    parameter int BOMB_FRAMES  = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  f_key,
    input  logic                  frame_tick,
    input  logic [9:0]            char_pos_x,
    input  logic [9:0]            char_pos_y,
    input  logic [NUM_LEVELS-1:0] coll_miner_in,
    input  logic [NUM_LEVELS-1:0] death_in,
    output logic [NUM_LEVELS-1:0] level_enable,
    output logic [2:0]            level_idx,
    output logic                  freeze,
    output logic                  char_reset,
    output logic [9:0]            bomb_pos_x,
    output logic [9:0]            bomb_pos_y,
    output logic [3:0]            b_cnt,
    output logic [1:0]            lives,
    output logic                  game_over,
    output logic                  win
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_RESCUED,
        S_DYING,
        S_GAME_OVER,
        S_WIN
    } state_t;

    state_t     state;
    logic [7:0] fc;
    logic [7:0] bomb_fc;
    logic       f_key_prev;
    logic       f_rise;
    logic [7:0] death_pad;
    logic [7:0] miner_pad;

    // Widen the per-part flags to the full index range so any level_idx selects safely.
    assign death_pad = 8'(death_in);
    assign miner_pad = 8'(coll_miner_in);
    assign f_rise    = f_key & ~f_key_prev;

    function automatic logic [NUM_LEVELS-1:0] onehot(input logic [2:0] idx);
        return NUM_LEVELS'(1) << idx;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            fc           <= 8'd0;
            bomb_fc      <= 8'd0;
            f_key_prev   <= 1'b0;
            level_enable <= '0;
            level_idx    <= 3'd0;
            freeze       <= 1'b1;
            char_reset   <= 1'b0;
            bomb_pos_x   <= 10'd0;
            bomb_pos_y   <= 10'd0;
            b_cnt        <= 4'd0;
            lives        <= 2'(LIVES);
            game_over    <= 1'b0;
            win          <= 1'b0;
        end else begin
            f_key_prev <= f_key;
            char_reset <= 1'b0;
            if (frame_tick) begin
                fc <= fc + 8'd1;
            end

            // Every state entry below clears fc, overriding the tick increment above.
            case (state)
                S_IDLE, S_GAME_OVER, S_WIN: begin
                    if (start) begin
                        state        <= S_PLAY;
                        fc           <= 8'd0;
                        level_idx    <= 3'd0;
                        level_enable <= onehot(3'd0);
                        lives        <= 2'(LIVES);
                        char_reset   <= 1'b1;
                        freeze       <= 1'b0;
                        game_over    <= 1'b0;
                        win          <= 1'b0;
                    end
                end

                S_PLAY: begin
                    if (death_pad[level_idx] || miner_pad[level_idx]) begin
                        state   <= death_pad[level_idx] ? S_DYING : S_RESCUED;
                        fc      <= 8'd0;
                        freeze  <= 1'b1;
                        b_cnt   <= 4'd0;
                        bomb_fc <= 8'd0;
                    end else if (b_cnt == 4'd0) begin
                        if (f_rise) begin
                            bomb_pos_x <= char_pos_x;
                            bomb_pos_y <= char_pos_y;
                            b_cnt      <= 4'd1;
                            bomb_fc    <= 8'd0;
                        end
                    end else if (frame_tick) begin
                        if (bomb_fc == 8'(BOMB_FRAMES - 1)) begin
                            bomb_fc <= 8'd0;
                            b_cnt   <= (b_cnt == 4'd3) ? 4'd0 : b_cnt + 4'd1;
                        end else begin
                            bomb_fc <= bomb_fc + 8'd1;
                        end
                    end
                end

                S_RESCUED: begin
                    if (fc == 8'(PAUSE_FRAMES)) begin
                        fc <= 8'd0;
                        if (level_idx == 3'(NUM_LEVELS - 1)) begin
                            state <= S_WIN;
                            win   <= 1'b1;
                        end else begin
                            state        <= S_PLAY;
                            level_idx    <= level_idx + 3'd1;
                            level_enable <= onehot(level_idx + 3'd1);
                            char_reset   <= 1'b1;
                            freeze       <= 1'b0;
                        end
                    end
                end

                S_DYING: begin
                    if (fc == 8'(PAUSE_FRAMES)) begin
                        fc    <= 8'd0;
                        lives <= lives - 2'd1;
                        if (lives == 2'd1) begin
                            state     <= S_GAME_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state      <= S_PLAY;
                            char_reset <= 1'b1;
                            freeze     <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    fc    <= 8'd0;
                end
            endcase
        end
    end

endmodule
